systolic_arbiter: RTL and testbench
===================================

SYSTOLIC_ARBITER -- requirements
Module: systolic_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing one systolic array.
REQ-002 Parameter IN_BEATS, default 4, 64-bit input beats per job.
REQ-003 Parameter OUT_BEATS, default 8, 64-bit result beats per job (16 x 32-bit = 512 bits).
REQ-004 Parameter TIMEOUT, default 1024, maximum COMPUTE cycles before abort.
REQ-005 clk input 1 clock; reset input 1, asynchronous, active-high.
REQ-006 req input NREQ, requester wants a job slot.
REQ-007 in_valid input NREQ, and in_data input NREQx64: requester input beat stream.
REQ-008 in_ready output NREQ, input beat accepted.
REQ-009 out_valid output NREQ, and out_data output 64 (shared): result beat to requester.
REQ-010 out_ready input NREQ, requester accepts result beat.
REQ-011 err output NREQ, one-cycle pulse when that requester's job is aborted.
REQ-012 busy output 1, and owner output clog2(NREQ): array currently granted, and to whom.
REQ-013 arr_start output 1, arr_data output 64, arr_src_valid output 1, arr_dest_ready input 1: job start and input stream to the array.
REQ-014 arr_res input 64, arr_res_valid input 1, arr_res_ready output 1: result stream from the array.

Function
REQ-015 FSM states IDLE, GRANT, LOAD, COMPUTE, DRAIN; state enum in package.
REQ-016 IDLE: if any req, round-robin select starting at (last_owner+1) mod NREQ, latch owner, go GRANT; otherwise stay.
REQ-017 GRANT: arr_start=1 for exactly one cycle, clear beat counter, go LOAD.
REQ-018 LOAD: arr_src_valid=in_valid[owner], arr_data=in_data[owner], in_ready[owner]=arr_dest_ready (combinational); non-owners in_ready=0.
REQ-019 An input beat counts when arr_src_valid && arr_dest_ready; after the IN_BEATS-th beat, go COMPUTE the next cycle.
REQ-020 COMPUTE: watchdog counter increments each cycle; on arr_res_valid go DRAIN with the counter cleared; on counter==TIMEOUT-1 without arr_res_valid, pulse err[owner], go IDLE.
REQ-021 DRAIN: out_valid[owner]=arr_res_valid, out_data=arr_res, arr_res_ready=out_ready[owner]; non-owners out_valid=0.
REQ-022 A result beat counts when arr_res_valid && arr_res_ready; after the OUT_BEATS-th beat, go IDLE and update last_owner=owner.
REQ-023 last_owner also updates on abort, so an aborting requester cannot starve others.
REQ-024 busy=1 in every state except IDLE; owner holds its latched value until the next grant.
REQ-025 Deasserting req after grant has no effect; the job runs to completion or timeout.
REQ-026 Simultaneous req from all requesters: exactly one grant, in rotating order across consecutive jobs.
REQ-027 Back-to-back: IDLE->GRANT takes one cycle, so a new grant follows DRAIN completion with one idle cycle minimum.
REQ-028 Beat counters are clog2(max(IN_BEATS,OUT_BEATS)+1) bits wide and never wrap within a job.

Reset
REQ-029 On reset: state=IDLE, owner=0, last_owner=NREQ-1 (so requester 0 wins first), counters=0.
REQ-030 During reset all outputs are 0: in_ready, out_valid, out_data, err, busy, arr_start, arr_src_valid, arr_data, arr_res_ready.
REQ-031 Reset mid-job abandons the job silently, with no err pulse; the array is reset by the same signal.

Structure
REQ-032 Package sys_pkg holds the arbiter state enum and default beat constants (IN_BEATS=4, OUT_BEATS=8).
REQ-033 Sub-module rr_arbiter (NREQ-wide request, last pointer, one-hot grant, combinational) is instantiated once.

Verification
REQ-034 req=01, 4 input beats, array returns 8 beats -> arr_start pulses once, in_ready[1]=0 throughout, 8 out_valid[0] handshakes, busy falls after the last beat.
REQ-035 req=11 held for 4 jobs -> grant order 0,1,0,1.
REQ-036 out_ready[0] low for 5 cycles mid-DRAIN -> arr_res_ready low for the same cycles; no beat lost or duplicated; data order preserved.
REQ-037 TIMEOUT=16 with the array never returning a result -> err[owner] high for exactly 1 cycle at COMPUTE cycle 16, state IDLE next cycle, next grant goes to the other requester.
REQ-038 reset asserted during LOAD after 2 beats -> all outputs 0 immediately; after release, req=10 is granted and requester 0 is next in order.
REQ-039 in_valid toggling 1,0,1,0 during LOAD -> exactly 4 beats forwarded; COMPUTE entered the cycle after the 4th handshake.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared types and defaults for the systolic array arbiter.
// State encoding plus beat/timeout defaults used by every file.
package sys_pkg;

  localparam int DATA_W        = 64;
  localparam int IN_BEATS_DEF  = 4;
  localparam int OUT_BEATS_DEF = 8;
  localparam int TIMEOUT_DEF   = 1024;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LOAD,
    COMPUTE,
    DRAIN
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_arbiter_if.sv
// Requester-side and array-side bundle of the arbiter.
// master is the arbiter's view, slave is everything around it.
interface systolic_arbiter_if
  import sys_pkg::*;
#(
  parameter int NREQ = 2
);

  localparam int OW = idx_w(NREQ);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             in_valid;
  logic [NREQ-1:0][DATA_W-1:0] in_data;
  logic [NREQ-1:0]             in_ready;
  logic [NREQ-1:0]             out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [NREQ-1:0]             out_ready;
  logic [NREQ-1:0]             err;
  logic                        busy;
  logic [OW-1:0]               owner;

  logic                        arr_start;
  logic [DATA_W-1:0]           arr_data;
  logic                        arr_src_valid;
  logic                        arr_dest_ready;
  logic [DATA_W-1:0]           arr_res;
  logic                        arr_res_valid;
  logic                        arr_res_ready;

  modport master (
    input  req,
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  arr_dest_ready,
    input  arr_res,
    input  arr_res_valid,
    output in_ready,
    output out_valid,
    output out_data,
    output err,
    output busy,
    output owner,
    output arr_start,
    output arr_data,
    output arr_src_valid,
    output arr_res_ready
  );

  modport slave (
    output req,
    output in_valid,
    output in_data,
    output out_ready,
    output arr_dest_ready,
    output arr_res,
    output arr_res_valid,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  err,
    input  busy,
    input  owner,
    input  arr_start,
    input  arr_data,
    input  arr_src_valid,
    input  arr_res_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick, searching upward from last+1.
// Produces a one-hot grant, all zero when nobody requests.
module rr_arbiter
  import sys_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int OW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last,
  output logic [NREQ-1:0] gnt
);

  int            j;
  logic [OW-1:0] k;
  logic          found;

  always_comb begin
    gnt   = '0;
    j     = 0;
    k     = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(last) + i;
      if (j >= NREQ) j = j - NREQ;
      k = OW'(j);
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_arbiter.sv
// Time-shares one systolic array between NREQ requesters:
// grant, stream input beats, wait with a watchdog, drain results.
module systolic_arbiter
  import sys_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int IN_BEATS  = IN_BEATS_DEF,
  parameter int OUT_BEATS = OUT_BEATS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input logic clk,
  input logic reset,
  systolic_arbiter_if.master bus
);

  localparam int OW = idx_w(NREQ);
  localparam int CW = $clog2(max2(IN_BEATS, OUT_BEATS) + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] IN_LAST  = CW'(IN_BEATS - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BEATS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [OW-1:0] OWN_RST  = OW'(NREQ - 1);

  arb_state_t      state, state_n;
  logic [OW-1:0]   owner, owner_n;
  logic [OW-1:0]   last_owner, last_n;
  logic [CW-1:0]   beat, beat_n;
  logic [WW-1:0]   wd, wd_n;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   gnt_idx;
  logic            in_hs;
  logic            out_hs;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req  (bus.req),
    .last (last_owner),
    .gnt  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = OW'(i);
    end
  end

  // last_owner starts at NREQ-1 so requester 0 wins the first pick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWN_RST;
      beat       <= '0;
      wd         <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      beat       <= beat_n;
      wd         <= wd_n;
    end
  end

  always_comb begin
    state_n           = state;
    owner_n           = owner;
    last_n            = last_owner;
    beat_n            = beat;
    wd_n              = wd;
    in_hs             = 1'b0;
    out_hs            = 1'b0;
    bus.in_ready      = '0;
    bus.out_valid     = '0;
    bus.out_data      = '0;
    bus.err           = '0;
    bus.busy          = (state != IDLE);
    bus.owner         = owner;
    bus.arr_start     = 1'b0;
    bus.arr_data      = '0;
    bus.arr_src_valid = 1'b0;
    bus.arr_res_ready = 1'b0;

    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          owner_n = gnt_idx;
          state_n = GRANT;
        end
      end

      GRANT: begin
        bus.arr_start = 1'b1;
        beat_n        = '0;
        state_n       = LOAD;
      end

      LOAD: begin
        bus.arr_src_valid   = bus.in_valid[owner];
        bus.arr_data        = bus.in_data[owner];
        bus.in_ready[owner] = bus.arr_dest_ready;
        in_hs = bus.in_valid[owner] && bus.arr_dest_ready;
        if (in_hs) begin
          if (beat == IN_LAST) begin
            beat_n  = '0;
            wd_n    = '0;
            state_n = COMPUTE;
          end else begin
            beat_n = beat + CW'(1);
          end
        end
      end

      COMPUTE: begin
        if (bus.arr_res_valid) begin
          wd_n    = '0;
          beat_n  = '0;
          state_n = DRAIN;
        end else if (wd == WD_LAST) begin
          // abort still rotates priority so a dead job cannot hog the array
          bus.err[owner] = 1'b1;
          wd_n           = '0;
          last_n         = owner;
          state_n        = IDLE;
        end else begin
          wd_n = wd + WW'(1);
        end
      end

      DRAIN: begin
        bus.out_valid[owner] = bus.arr_res_valid;
        bus.out_data         = bus.arr_res;
        bus.arr_res_ready    = bus.out_ready[owner];
        out_hs = bus.arr_res_valid && bus.out_ready[owner];
        if (out_hs) begin
          if (beat == OUT_LAST) begin
            beat_n  = '0;
            last_n  = owner;
            state_n = IDLE;
          end else begin
            beat_n = beat + CW'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_systolic_arbiter.sv
// Directed bench for systolic_arbiter with two requesters.
// Inputs change just after rising edges, outputs are read on falling edges.
module tb_systolic_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  systolic_arbiter_if #(.NREQ(2)) bus ();

  systolic_arbiter #(
    .NREQ      (2),
    .IN_BEATS  (4),
    .OUT_BEATS (8),
    .TIMEOUT   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] oh(input int o);
    logic [1:0] v;
    v = 2'b01;
    return v << o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_start"}, bus.arr_start, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 2'b00);
    chk({tag, "_out_valid"}, bus.out_valid, 2'b00);
    chk({tag, "_out_data"}, bus.out_data, 64'h0);
    chk({tag, "_err"}, bus.err, 2'b00);
    chk({tag, "_src_valid"}, bus.arr_src_valid, 1'b0);
    chk({tag, "_arr_data"}, bus.arr_data, 64'h0);
    chk({tag, "_res_ready"}, bus.arr_res_ready, 1'b0);
    chk({tag, "_owner"}, bus.owner, 1'b0);
  endtask

  task automatic drive_noisy();
    bus.req            = 2'b11;
    bus.in_valid       = 2'b11;
    bus.in_data[0]     = '1;
    bus.in_data[1]     = '1;
    bus.out_ready      = 2'b11;
    bus.arr_dest_ready = 1'b1;
    bus.arr_res        = '1;
    bus.arr_res_valid  = 1'b1;
  endtask

  task automatic idle_cycle();
    next_cyc();
    bus.in_valid      = 2'b00;
    bus.arr_res_valid = 1'b1;
    bus.out_ready     = 2'b11;
    look();
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_start", bus.arr_start, 1'b0);
    chk("idle_out_valid", bus.out_valid, 2'b00);
    chk("idle_res_ready", bus.arr_res_ready, 1'b0);
  endtask

  task automatic grant_cycle(input int o, input logic [1:0] req_now);
    next_cyc();
    bus.req           = req_now;
    bus.in_valid      = 2'b11;
    bus.arr_res_valid = 1'b0;
    look();
    chk("grant_start", bus.arr_start, 1'b1);
    chk("grant_owner", bus.owner, o[0]);
    chk("grant_busy", bus.busy, 1'b1);
    chk("grant_in_ready", bus.in_ready, 2'b00);
    chk("grant_src_valid", bus.arr_src_valid, 1'b0);
  endtask

  task automatic do_load(input int o, input logic [63:0] base,
                         input bit toggle, input int nb);
    int   b;
    int   c;
    logic v;
    logic rdy;
    b = 0;
    c = 0;
    while (b < nb) begin
      next_cyc();
      v   = toggle ? (c % 2 == 0) : 1'b1;
      rdy = toggle ? 1'b1 : (c != 1);
      bus.in_valid[o]    = v;
      bus.in_valid[1-o]  = 1'b1;
      bus.in_data[o]     = base + 64'(b);
      bus.in_data[1-o]   = 64'hDEAD_BEEF;
      bus.arr_dest_ready = rdy;
      look();
      chk("ld_src_valid", bus.arr_src_valid, v);
      chk("ld_data", bus.arr_data, base + 64'(b));
      chk("ld_in_ready", bus.in_ready, rdy ? oh(o) : 2'b00);
      chk("ld_start", bus.arr_start, 1'b0);
      if (v && rdy) b++;
      c++;
    end
  endtask

  task automatic do_compute(input int n, input logic [63:0] base);
    for (int c = 1; c <= n + 1; c++) begin
      next_cyc();
      bus.in_valid       = 2'b11;
      bus.arr_dest_ready = 1'b1;
      bus.out_ready      = 2'b11;
      bus.arr_res        = base;
      bus.arr_res_valid  = (c == n + 1);
      look();
      chk("cmp_src_valid", bus.arr_src_valid, 1'b0);
      chk("cmp_in_ready", bus.in_ready, 2'b00);
      chk("cmp_out_valid", bus.out_valid, 2'b00);
      chk("cmp_res_ready", bus.arr_res_ready, 1'b0);
      chk("cmp_busy", bus.busy, 1'b1);
      chk("cmp_err", bus.err, 2'b00);
    end
  endtask

  task automatic do_abort(input int o);
    for (int c = 1; c <= 16; c++) begin
      next_cyc();
      bus.in_valid      = 2'b11;
      bus.arr_res_valid = 1'b0;
      look();
      chk("abort_err", bus.err, (c == 16) ? oh(o) : 2'b00);
      chk("abort_busy", bus.busy, 1'b1);
    end
    next_cyc();
    look();
    chk("abort_idle_busy", bus.busy, 1'b0);
    chk("abort_idle_err", bus.err, 2'b00);
  endtask

  task automatic do_drain(input int o, input logic [63:0] base,
                          input int stall_at, input int stall_len);
    int   k;
    int   s;
    logic stall;
    k = 0;
    s = 0;
    while (k < 8) begin
      next_cyc();
      stall = (k == stall_at) && (s < stall_len);
      bus.in_valid       = 2'b00;
      bus.arr_res_valid  = 1'b1;
      bus.arr_res        = base + 64'(k);
      bus.out_ready[o]   = !stall;
      bus.out_ready[1-o] = 1'b1;
      look();
      chk("dr_out_valid", bus.out_valid, oh(o));
      chk("dr_out_data", bus.out_data, base + 64'(k));
      chk("dr_res_ready", bus.arr_res_ready, !stall);
      chk("dr_busy", bus.busy, 1'b1);
      if (stall) s++;
      else k++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_noisy();

    // outputs held at zero while reset is high despite busy inputs
    next_cyc();
    next_cyc();
    look();
    all_zero("rst");

    next_cyc();
    reset              = 1'b0;
    bus.req            = 2'b01;
    bus.in_valid       = 2'b00;
    bus.out_ready      = 2'b00;
    bus.arr_dest_ready = 1'b0;
    bus.arr_res_valid  = 1'b0;
    look();
    chk("rel_busy", bus.busy, 1'b0);

    // single job for requester 0, req dropped after grant
    grant_cycle(0, 2'b00);
    do_load(0, 64'hA0, 1'b0, 4);
    do_compute(2, 64'hD0);
    do_drain(0, 64'hD0, -1, 0);
    idle_cycle();

    // fresh reset, both requesters hold req for four jobs
    next_cyc();
    reset = 1'b1;
    look();
    chk("rst2_busy", bus.busy, 1'b0);
    next_cyc();
    reset   = 1'b0;
    bus.req = 2'b11;
    look();
    chk("rel2_busy", bus.busy, 1'b0);
    for (int j = 0; j < 4; j++) begin
      grant_cycle(j % 2, 2'b11);
      do_load(j % 2, 64'h1000 * (j + 1), 1'b0, 4);
      do_compute(0, 64'h2000 * (j + 1));
      do_drain(j % 2, 64'h2000 * (j + 1), -1, 0);
      idle_cycle();
    end

    // requester 0 stalls out_ready for five cycles mid-drain
    grant_cycle(0, 2'b01);
    do_load(0, 64'h100, 1'b0, 4);
    do_compute(1, 64'h200);
    do_drain(0, 64'h200, 3, 5);
    idle_cycle();

    // array never answers: watchdog abort, then the other side wins
    grant_cycle(0, 2'b11);
    do_load(0, 64'h300, 1'b0, 4);
    do_abort(0);
    grant_cycle(1, 2'b11);

    // reset lands after two load beats
    do_load(1, 64'h400, 1'b0, 2);
    next_cyc();
    drive_noisy();
    reset = 1'b1;
    look();
    all_zero("midrst");
    next_cyc();
    reset              = 1'b0;
    bus.req            = 2'b10;
    bus.in_valid       = 2'b00;
    bus.out_ready      = 2'b00;
    bus.arr_res_valid  = 1'b0;
    look();
    chk("rel3_busy", bus.busy, 1'b0);

    // toggling in_valid while loading for requester 1
    grant_cycle(1, 2'b11);
    do_load(1, 64'h500, 1'b1, 4);
    do_compute(0, 64'h600);
    do_drain(1, 64'h600, -1, 0);
    idle_cycle();

    grant_cycle(0, 2'b00);
    do_load(0, 64'h700, 1'b0, 4);
    do_compute(3, 64'h800);
    do_drain(0, 64'h800, -1, 0);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
